// File: rtl/block_ram_responder.sv
// block_ram_responder: serves cache block refills (reads) and writebacks (writes) from a
// word-organised backing RAM, one word per cycle after an optional fixed access latency,
// and reports completion with a single-cycle registered ram_ready pulse.
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   ram_en_in         : request valid, held by the cache until ram_ready
//   ram_write_in      : 1 = block write (writeback), 0 = block read (refill)
//   ram_addr_in       : block-aligned word address (offset bits ignored, wraps modulo RAM depth)
//   block_wb_in       : writeback block, word i at [DATA_WIDTH*i +: DATA_WIDTH]
//   ram_ready         : one-cycle completion pulse
//   block_out         : read block, same word ordering as block_wb_in
//
// Build option: define BLOCK_RAM_LATENCY_EN to insert LATENCY wait cycles before each
// transfer; when undefined the WAIT state and wait counter are compiled out.
module block_ram_responder #(
  parameter int OFFSET_WIDTH   = 3,
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LATENCY        = 4,
  parameter int BLOCK_WIDTH    = DATA_WIDTH * (1 << OFFSET_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ram_en_in,
  input  logic                   ram_write_in,
  input  logic [ADDR_WIDTH-1:0]  ram_addr_in,
  input  logic [BLOCK_WIDTH-1:0] block_wb_in,
  output logic                   ram_ready,
  output logic [BLOCK_WIDTH-1:0] block_out
);

  localparam int BLOCK_SIZE = 1 << OFFSET_WIDTH;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(BLOCK_SIZE - 1);

`ifdef BLOCK_RAM_LATENCY_EN
  localparam int EFF_LATENCY = LATENCY;
`else
  localparam int EFF_LATENCY = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      is_write;
  logic [MEM_ADDR_WIDTH-1:0] base;
  logic [OFFSET_WIDTH-1:0]   word_cnt;
  logic [BLOCK_WIDTH-1:0]    wb_buf;
  logic [BLOCK_WIDTH-1:0]    rd_buf;
  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] xfer_addr;

`ifdef BLOCK_RAM_LATENCY_EN
  logic [3:0] wait_cnt;
`endif

  // Address bits outside the RAM window and the in-block offset are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_in[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                              ram_addr_in[OFFSET_WIDTH-1:0]};

  assign xfer_addr = base + MEM_ADDR_WIDTH'(word_cnt);
  assign block_out = rd_buf;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ram_en_in) begin
          state_nxt = (EFF_LATENCY > 0) ? S_WAIT : S_XFER;
        end
      end
      S_WAIT: begin
`ifdef BLOCK_RAM_LATENCY_EN
        if (wait_cnt == 4'(EFF_LATENCY - 1)) begin
          state_nxt = S_XFER;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      S_XFER: begin
        if (word_cnt == LAST_WORD) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters, request latches and read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      ram_ready <= 1'b0;
      rd_buf    <= '0;
`ifdef BLOCK_RAM_LATENCY_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      // Registered so the pulse coincides exactly with the DONE cycle.
      ram_ready <= (state == S_XFER) && (word_cnt == LAST_WORD);
      case (state)
        S_IDLE: begin
          if (ram_en_in) begin
            is_write <= ram_write_in;
            base     <= {ram_addr_in[MEM_ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            word_cnt <= '0;
`ifdef BLOCK_RAM_LATENCY_EN
            wait_cnt <= '0;
`endif
            if (ram_write_in) begin
              wb_buf <= block_wb_in;
            end
          end
        end
        S_WAIT: begin
`ifdef BLOCK_RAM_LATENCY_EN
          wait_cnt <= wait_cnt + 4'd1;
`endif
        end
        S_XFER: begin
          if (!is_write) begin
            rd_buf[int'(word_cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem[xfer_addr];
          end
          // Wraps to zero after the last word, ready for the next request.
          word_cnt <= word_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Backing RAM write port. Reset suppresses the write in flight so an interrupted
  // writeback leaves only the words completed before the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_XFER) && is_write) begin
      mem[xfer_addr] <= wb_buf[int'(word_cnt)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_block_ram_responder.sv
module tb_block_ram_responder;

  localparam int OW  = 3;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int MAW = 12;
  localparam int LAT = 4;
  localparam int BS  = 1 << OW;
  localparam int BW  = DW * BS;
`ifdef BLOCK_RAM_LATENCY_EN
  localparam int EL = LAT;
`else
  localparam int EL = 0;
`endif
  localparam int RDY_CYC = EL + BS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en_in;
  logic          ram_write_in;
  logic [AW-1:0] ram_addr_in;
  logic [BW-1:0] block_wb_in;
  logic          ram_ready;
  logic [BW-1:0] block_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int            lat;
    logic [BW-1:0] blk;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdat;
    logic [BW-1:0] exp;
    bit            hold;
    bit            chk_gap;
  } vec_t;
  vec_t vecs[8];

  block_ram_responder #(
    .OFFSET_WIDTH(OW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_ADDR_WIDTH(MAW), .LATENCY(LAT), .BLOCK_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .ram_en_in(ram_en_in), .ram_write_in(ram_write_in),
    .ram_addr_in(ram_addr_in), .block_wb_in(block_wb_in),
    .ram_ready(ram_ready), .block_out(block_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] pat(input int b);
    logic [BW-1:0] p;
    p = '0;
    for (int i = 0; i < BS; i++) p[i*DW +: DW] = DW'(b + i);
    return p;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drives a request at the current time (1 time unit after an edge), pushes the
  // expectation, then waits for ram_ready and checks it against the scoreboard.
  task automatic transact(input bit write, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wdat, input logic [BW-1:0] exp,
                          input bit hold, output int rdy_cyc);
    exp_t e;
    bit   got;
    ram_en_in    = 1'b1;
    ram_write_in = write;
    ram_addr_in  = addr;
    block_wb_in  = wdat;
    sb.push_back('{RDY_CYC, exp});
    got = 1'b0;
    rdy_cyc = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge clk); #1;
      if (!hold) begin
        // Request already accepted; scramble everything to prove it is ignored.
        ram_en_in    = 1'b0;
        ram_write_in = ~write;
        ram_addr_in  = ~addr;
        block_wb_in  = ~wdat;
      end
      if (ram_ready) begin
        got = 1'b1;
        e = sb.pop_front();
        check("ready_cycle", BW'(k), BW'(e.lat));
        check("block_out", block_out, e.blk);
        rdy_cyc = cyc;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got no ram_ready required one in cycle %0d", RDY_CYC);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    check("ready_single_pulse", BW'(ram_ready), BW'(0));
    ram_en_in = 1'b0;
  endtask

  initial begin
    int prev;
    int now;
    logic [BW-1:0] e;

    vecs[0] = '{1'b1, 30'h40,   pat(32'hA0),   '0,              1'b1, 1'b0};
    vecs[1] = '{1'b0, 30'h43,   '0,            pat(32'hA0),     1'b1, 1'b0};
    vecs[2] = '{1'b1, 30'h80,   pat(32'h1000), pat(32'hA0),     1'b1, 1'b0};
    vecs[3] = '{1'b0, 30'h80,   '0,            pat(32'h1000),   1'b1, 1'b1};
    vecs[4] = '{1'b1, 30'h100,  pat(32'h5500), pat(32'h1000),   1'b1, 1'b0};
    vecs[5] = '{1'b1, 30'h1010, pat(32'h2000), pat(32'h1000),   1'b1, 1'b0};
    vecs[6] = '{1'b0, 30'h10,   '0,            pat(32'h2000),   1'b1, 1'b0};
    vecs[7] = '{1'b0, 30'h40,   '0,            pat(32'hA0),     1'b0, 1'b0};

    rst          = 1'b1;
    ram_en_in    = 1'b0;
    ram_write_in = 1'b0;
    ram_addr_in  = '0;
    block_wb_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ram_ready", BW'(ram_ready), BW'(0));
    check("reset_block_out", block_out, '0);

    prev = 0;
    for (int i = 0; i < 8; i++) begin
      transact(vecs[i].write, vecs[i].addr, vecs[i].wdat, vecs[i].exp, vecs[i].hold, now);
      if (vecs[i].chk_gap) check("ready_gap", BW'(now - prev), BW'(EL + BS + 2));
      prev = now;
    end

    // Reset during the third XFER cycle of a writeback over the 0x55xx pattern.
    ram_en_in    = 1'b1;
    ram_write_in = 1'b1;
    ram_addr_in  = 30'h100;
    block_wb_in  = pat(32'hFF00);
    repeat (EL + 3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    ram_en_in = 1'b0;
    check("midreset_ram_ready", BW'(ram_ready), BW'(0));
    check("midreset_block_out", block_out, '0);

    e = pat(32'h5500);
    e[0 +: DW]  = 32'hFF00;
    e[DW +: DW] = 32'hFF01;
    transact(1'b0, 30'h100, '0, e, 1'b1, now);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_ram_responder.md
# block_ram_responder

Memory-side responder for the cache block-transfer interface. It accepts a block read (refill) or block write (writeback) request held by the cache manage unit and serves it from a word-organised backing RAM, one word per cycle after an optional fixed access latency. It signals completion with a one-cycle `ram_ready` pulse, which is the event the cache uses to advance its miss state. It sits between the cache manage unit and the (simulated or FPGA-block) main memory.

## Interface
- `OFFSET_WIDTH`, default 3: word offset bits within a block; `BLOCK_SIZE = 1 << OFFSET_WIDTH`.
- `ADDR_WIDTH`, default 30: word-address width.
- `DATA_WIDTH`, default 32: word width.
- `MEM_ADDR_WIDTH`, default 12: backing RAM depth is `1 << MEM_ADDR_WIDTH` words.
- `LATENCY`, default 4: wait cycles before a transfer starts; range 0..15.
- `BLOCK_WIDTH`, derived: `DATA_WIDTH * BLOCK_SIZE`.

Ports:
- `clk  in  1`: single clock; all logic on posedge.
- `rst  in  1`: synchronous, active-high reset.
- `ram_en_in  in  1`: request valid; the cache holds it high, with address and data stable, until `ram_ready`.
- `ram_write_in  in  1`: 1 = block write (writeback), 0 = block read.
- `ram_addr_in  in  ADDR_WIDTH`: block-aligned word address; low `OFFSET_WIDTH` bits are ignored.
- `block_wb_in  in  BLOCK_WIDTH`: writeback block; word i occupies `[DATA_WIDTH*i +: DATA_WIDTH]`.
- `ram_ready  out  1`: one-cycle completion pulse (registered).
- `block_out  out  BLOCK_WIDTH`: read block; same word ordering as `block_wb_in`.

## Operation
- States: IDLE, WAIT, XFER, DONE. State is held in a 2-bit register, plus a wait counter (4 bits) and a word counter (`OFFSET_WIDTH` bits).
- **IDLE**
  - If `ram_en_in` = 1, latch `ram_write_in`.
  - Latch base = `{ram_addr_in[MEM_ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'b0}`. Upper address bits are ignored, so addresses wrap modulo RAM depth.
  - On a write request, latch `block_wb_in` into the writeback buffer.
  - Go to WAIT if effective latency > 0, otherwise go to XFER. Word counter = 0.
- **WAIT**: wait counter counts up to the effective latency minus 1, then the block goes to XFER.
- **XFER**
  - Each cycle handles word j = word counter, at RAM address base + j.
  - Read: capture `mem[base+j]` into read-buffer slot j.
  - Write: store buffer word j into `mem[base+j]`.
  - When j = `BLOCK_SIZE`-1, go to DONE. Otherwise increment j.
- **DONE**: `ram_ready` = 1 for this cycle only, then go to IDLE unconditionally.
- A new request is sampled no earlier than the cycle after DONE. This gives the cache one cycle to update its status, and the next request may be back-to-back, e.g. writeback followed by refill.
- Once a request is accepted it runs to completion. `ram_en_in`, `ram_addr_in` and `block_wb_in` are ignored after acceptance; dropping `ram_en_in` mid-transfer does not cancel it.
- `block_out` is driven by the read buffer.
  - It changes only during read XFER cycles.
  - It is stable from the DONE cycle until the next read's first XFER cycle.
  - Writes never alter it.
- Reset mid-operation:
  - Go to IDLE, clear counters, `ram_ready` = 0, read buffer = 0.
  - RAM contents are untouched; words already written by a partial writeback remain.

## Timing
- Reset values: `ram_ready` = 0, `block_out` = 0, state IDLE.
- Latency: with `ram_en_in` first sampled high in IDLE in cycle 0, `ram_ready` is high in cycle `L + BLOCK_SIZE + 1`, where L is the effective latency. With defaults this is cycle 13.
- Minimum spacing between two `ram_ready` pulses is `L + BLOCK_SIZE + 2` cycles.
- Reads from the backing RAM are asynchronous (combinational array read, registered into the buffer). Writes are synchronous.
- `ram_ready` is never high for two consecutive cycles.

## Configuration
- `BLOCK_RAM_LATENCY_EN`:
  - Defined: effective latency = `LATENCY` and the WAIT state is used.
  - Undefined: effective latency = 0, WAIT and the wait counter are compiled out, and IDLE goes straight to XFER. `ram_ready` then arrives in cycle `BLOCK_SIZE + 1`, i.e. cycle 9.

## Test plan
- **Read with latency:** macro defined, defaults. Preload `mem[0x40+i]` = `0xA0+i`; hold en=1, write=0, addr=0x43 from cycle 0. Expect `ram_ready` only in cycle 13, and `block_out` word i = `0xA0+i` (base 0x40, low bits ignored).
- **Writeback then refill:** write request for addr 0x80 with word i = `0x1000+i`; after `ram_ready`, change to a read of 0x80 in the next cycle.
  - The read is accepted one cycle after DONE; the second `ram_ready` comes 14 cycles after the first.
  - `block_out` returns `0x1000+i`.
- **Reset mid-write:** write of 0x100 with word i = `0xFF00+i`; assert `rst` in the 3rd XFER cycle.
  - `mem[0x100..0x101]` are written and `mem[0x102..0x107]` are unchanged.
  - `ram_ready` = 0 and `block_out` = 0 after reset; the next request completes normally.
- **Enable dropped:** assert en for one cycle only, then deassert. The transfer still completes and `ram_ready` pulses once in cycle 13.
- **Address wrap:** addr = `0x1000 + 0x10` with `MEM_ADDR_WIDTH`=12 accesses `mem[0x10..0x17]`.
- **Macro undefined:** repeat the first scenario; `ram_ready` arrives in cycle 9 with identical data.
